// File: rtl/ysyx_22041207_ex_muldiv.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional YSYX_22041207_MULDIV_EARLY_OUT_EN finishes trivial cases in one cycle.
module ysyx_22041207_ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [2:0]  op,
  input  logic        word,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [63:0] result,
  output logic        stall
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q;
  logic [6:0]     cnt_q;
  logic [127:0]   acc_q;
  logic [63:0]    mcand_q;
  logic [2:0]     op_q;
  logic           word_q;
  logic           neg_q;
  logic           out_valid_q;
  logic [63:0]    result_q;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Operand preparation for acceptance in IDLE.
  logic        eff_word, sgn1_en, sgn2_en, is_div, is_rem;
  logic [63:0] a_ext, b_ext, mag1, mag2;
  logic        s1, s2, dz, neg_acc;

  always_comb begin
    eff_word = word & ((op == 3'd0) | op[2]);
    sgn1_en  = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
    sgn2_en  = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
    is_div   = op[2];
    is_rem   = op[2] & op[1];
    a_ext    = src1;
    b_ext    = src2;
    if (eff_word) begin
      a_ext = sgn1_en ? sext32(src1[31:0]) : {32'b0, src1[31:0]};
      b_ext = sgn2_en ? sext32(src2[31:0]) : {32'b0, src2[31:0]};
    end
    s1      = sgn1_en & a_ext[63];
    s2      = sgn2_en & b_ext[63];
    mag1    = s1 ? (~a_ext + 64'd1) : a_ext;
    mag2    = s2 ? (~b_ext + 64'd1) : b_ext;
    dz      = (b_ext == 64'd0);
    // Quotient sign is suppressed on divide-by-zero so the all-ones result survives.
    if (is_rem)      neg_acc = s1;
    else if (is_div) neg_acc = (s1 ^ s2) & ~dz;
    else             neg_acc = s1 ^ s2;
  end

`ifdef YSYX_22041207_MULDIV_EARLY_OUT_EN
  logic        early_hit, ovf;
  logic [63:0] early_res;

  always_comb begin
    early_hit = 1'b0;
    early_res = 64'd0;
    ovf = sgn2_en & is_div & (b_ext == '1) &
          (eff_word ? (a_ext == 64'hFFFF_FFFF_8000_0000) : (a_ext == 64'h8000_0000_0000_0000));
    if (is_div) begin
      if (dz) begin
        early_hit = 1'b1;
        early_res = is_rem ? (eff_word ? sext32(src1[31:0]) : src1) : '1;
      end else if (ovf) begin
        early_hit = 1'b1;
        early_res = is_rem ? 64'd0 : a_ext;
      end
    end else if ((a_ext == 64'd0) || (b_ext == 64'd0)) begin
      early_hit = 1'b1;
    end
  end
`endif

  // One iteration step and final sign fix on the stepped accumulator.
  logic [64:0]  mul_sum;
  logic [64:0]  r_sh;
  logic         borrow;
  logic [63:0]  r_new;
  logic [127:0] acc_step;
  logic [127:0] prod;
  logic [63:0]  res_fin;

  always_comb begin
    mul_sum = {1'b0, acc_q[127:64]} + {1'b0, mcand_q};
    r_sh    = {acc_q[127:64], acc_q[63]};
    borrow  = r_sh < {1'b0, mcand_q};
    r_new   = borrow ? r_sh[63:0] : (r_sh[63:0] - mcand_q);
    if (op_q[2])        acc_step = {r_new, acc_q[62:0], ~borrow};
    else if (acc_q[0])  acc_step = {mul_sum, acc_q[63:1]};
    else                acc_step = {1'b0, acc_q[127:1]};

    // W multiplies run 32 steps, leaving the product shifted up by 32.
    prod = word_q ? {32'b0, acc_step[127:32]} : acc_step;
    if (neg_q) prod = -prod;
    case (op_q)
      3'd0:                res_fin = prod[63:0];
      3'd1, 3'd2, 3'd3:    res_fin = prod[127:64];
      3'd4, 3'd5:          res_fin = neg_q ? -acc_step[63:0] : acc_step[63:0];
      default:             res_fin = neg_q ? -acc_step[127:64] : acc_step[127:64];
    endcase
    if (word_q) res_fin = sext32(res_fin[31:0]);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 7'd0;
      acc_q       <= 128'd0;
      mcand_q     <= 64'd0;
      op_q        <= 3'd0;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 64'd0;
    end else if (flush) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q    <= op;
            word_q  <= eff_word;
            neg_q   <= neg_acc;
            cnt_q   <= eff_word ? 7'd32 : 7'd64;
            mcand_q <= is_div ? mag2 : mag1;
            // W dividends sit in the top half so their MSB shifts out first.
            acc_q   <= is_div ? {64'd0, (eff_word ? {mag1[31:0], 32'd0} : mag1)}
                              : {64'd0, mag2};
`ifdef YSYX_22041207_MULDIV_EARLY_OUT_EN
            if (early_hit) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              result_q    <= early_res;
            end else begin
              state_q <= StCalc;
            end
`else
            state_q <= StCalc;
`endif
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            result_q    <= res_fin;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign stall     = in_valid & ~out_valid_q;

endmodule

// File: tb/tb_ysyx_22041207_ex_muldiv.sv
// Directed vector bench for the iterative multiply/divide unit.
module tb_ysyx_22041207_ex_muldiv;

  logic        clk, rst_n, flush, in_valid, word, out_ready;
  logic [2:0]  op;
  logic [63:0] src1, src2;
  logic        out_valid, stall;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef YSYX_22041207_MULDIV_EARLY_OUT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  ysyx_22041207_ex_muldiv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .op        (op),
    .word      (word),
    .src1      (src1),
    .src2      (src2),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .result    (result),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic        early;
  } vec_t;

  vec_t vecs[20];

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b);
    in_valid = 1'b1;
    op       = o;
    word     = w;
    src1     = a;
    src2     = b;
  endtask

  // Called just after driving in cycle 0; returns the cycle out_valid is first seen (-1 on timeout).
  task automatic wait_done(input int limit, output int cycles, output int stalls);
    #1;
    stalls = stall ? 1 : 0;
    cycles = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cycles = k;
        break;
      end
      if (stall) stalls++;
    end
  endtask

  initial begin
    int cyc, stl, exp_cyc;
    bit seen;
    logic [63:0] held;

    vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[2]  = '{3'd1, 1'b0, '1, '1, 64'd0, 1'b0};
    vecs[3]  = '{3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[4]  = '{3'd0, 1'b0, 64'd0, 64'd5, 64'd0, 1'b1};
    vecs[5]  = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[6]  = '{3'd4, 1'b1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1'b1};
    vecs[7]  = '{3'd6, 1'b1, 64'h8000_0000, '1, 64'd0, 1'b1};
    vecs[8]  = '{3'd5, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[9]  = '{3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 1'b1};
    vecs[10] = '{3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0};
    vecs[11] = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[12] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[13] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1};
    vecs[14] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1'b1};
    vecs[15] = '{3'd4, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[16] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1};
    vecs[17] = '{3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h0FFF_FFFF, 1'b0};
    vecs[18] = '{3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[19] = '{3'd3, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = 3'd0; word = 1'b0;
    src1 = '0; src2 = '0; out_ready = 1'b1;
    #2;
    chkint("reset_out_valid", int'(out_valid), 0);
    chk64("reset_result", result, 64'd0);
    chkint("reset_stall_idle", int'(stall), 0);
    in_valid = 1'b1; #1;
    chkint("reset_stall_follows_in_valid", int'(stall), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b);
      exp_cyc = (vecs[i].early && EarlyEn) ? 1 :
                ((vecs[i].word && (vecs[i].op == 3'd0 || vecs[i].op[2])) ? 33 : 65);
      wait_done(200, cyc, stl);
      chk64($sformatf("vec%0d_result", i), result, vecs[i].exp);
      chkint($sformatf("vec%0d_latency", i), cyc, exp_cyc);
      chkint($sformatf("vec%0d_stall_cycles", i), stl, exp_cyc);
      in_valid = 1'b0;
    end

    // REM held in DONE with a younger op waiting on in_valid.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
    wait_done(200, cyc, stl);
    chkint("hold_latency", cyc, 65);
    chk64("hold_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    drive(3'd5, 1'b0, 64'd100, 64'd7);
    seen = 1'b0;
    held = result;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      if (!out_valid || result !== 64'hFFFF_FFFF_FFFF_FFFE) seen = 1'b1;
    end
    chkint("hold_stable", int'(seen), 0);
    chk64("hold_result_end", result, held);
    out_ready = 1'b1;
    wait_done(200, cyc, stl);
    chkint("handoff_next_latency", cyc, 66);
    chk64("handoff_next_result", result, 64'd14);
    in_valid = 1'b0;

    // Flush in cycle 10 of a DIV, then the next op starts on the following edge.
    @(posedge clk); #1;
    drive(3'd4, 1'b0, 64'd100, 64'd7);
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    chkint("flush_no_valid_before", int'(seen), 0);
    chkint("flush_out_valid", int'(out_valid), 0);
    flush = 1'b0;
    drive(3'd6, 1'b0, 64'd100, 64'd7);
    wait_done(200, cyc, stl);
    chkint("after_flush_latency", cyc, 65);
    chkint("after_flush_stall_cycles", stl, 65);
    chk64("after_flush_result", result, 64'd2);
    in_valid = 1'b0;

    // Asynchronous reset in cycle 20 of a DIV.
    @(posedge clk); #1;
    drive(3'd4, 1'b0, 64'd100, 64'd7);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chkint("midreset_out_valid", int'(out_valid), 0);
    chk64("midreset_result", result, 64'd0);
    chkint("midreset_stall", int'(stall), 1);
    in_valid = 1'b0;
    #1;
    chkint("midreset_stall_low", int'(stall), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(3'd0, 1'b0, 64'd6, 64'd7);
    wait_done(200, cyc, stl);
    chkint("post_reset_latency", cyc, 65);
    chk64("post_reset_result", result, 64'd42);
    in_valid = 1'b0;

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_ex_muldiv.md
# ysyx_22041207_ex_muldiv

Iterative RV64M multiply/divide unit inside the EX stage, directly downstream of the ID/EX pipeline register. It captures operands when EX presents an M-extension instruction and computes one result bit per cycle. While busy it drives the stall that freezes IF/ID and ID/EX, and it hands the 64-bit result to EX write-back.

## Interface
- No parameters; XLEN fixed at 64.
- `clk` in 1: stage clock; all state updates on the falling edge, matching the pipeline registers.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: kill the in-flight operation (branch/trap redirect).
- `in_valid` in 1: EX holds an M-extension instruction.
- `op` in 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `word` in 1: W-variant; 32-bit operation, result sign-extended to 64 bits. Ignored for ops 1–3.
- `src1`, `src2` in 64: rs1/rs2 operand values after forwarding.
- `out_ready` in 1: EX advances this cycle (no other stall).
- `out_valid` out 1: `result` is valid.
- `result` out 64: final value.
- `stall` out 1: combinational `in_valid & ~out_valid`. Drives the ID/EX bubble.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `in_valid` and no `flush`: latch the operands and go to CALC.
  - `cnt` = 64, or 32 when `word` is set.
  - Latched operands are magnitudes plus sign flags. DIV/REM/MULH use both signs. MULHSU uses the `src1` sign only. Unsigned ops use no signs.
  - For W ops, operands are the low 32 bits, sign- or zero-extended per op.
- CALC, multiply: shift-add. Each edge adds the multiplicand to the upper half of a 128-bit accumulator when the multiplier LSB is 1, then shifts right one bit.
- CALC, divide: restoring. Each edge shifts the remainder left, brings in the next dividend bit, subtracts the divisor if no borrow, and shifts the quotient bit in.
- CALC: `cnt` decrements every edge; on the edge where it reaches 0, go to DONE.
- DONE:
  - Apply the sign fix and select the result.
  - MUL takes the low 64 bits. MULH* take the high 64 bits, negating the 128-bit product when the signs differ.
  - DIV quotient is negative when the signs differ. REM takes the dividend's sign.
  - W ops sign-extend bit 31.
- DONE holds `result` and `out_valid` = 1 until `out_ready`, then goes to IDLE. A new `in_valid` is never accepted in DONE.
- Divide by zero (required values): quotient = all ones (W: 0xFFFFFFFFFFFFFFFF), remainder = dividend (W: sign-extended low 32).
- Signed overflow, MIN / −1 (required values): quotient = MIN (W: 0xFFFFFFFF80000000), remainder = 0.
- `flush` at any edge takes precedence over every other transition: go to IDLE, clear `out_valid`. `in_valid` is not accepted on that edge.
- Reset mid-operation: the same effect as `flush`, asynchronously.

## Timing
- Reset values: state IDLE, `out_valid` 0, `result` 0, `cnt` 0, all datapath registers 0. `stall` follows `in_valid` combinationally.
- Acceptance is edge 0. Iterations occur on edges 1..N, with N = 64, or 32 for W ops.
- `out_valid` rises after edge N. It is visible in cycle N+1 (65 or 33) counting from the acceptance edge.
- `stall` is high from the first cycle `in_valid` is seen until `out_valid` is high. That is 65 (or 33) stall cycles minimum.
- `result` is stable whenever `out_valid` = 1.
- If `out_ready` = 0 in DONE, `out_valid` and `result` hold indefinitely.
- Back-to-back ops: the earliest acceptance of the next op is the edge after the DONE→IDLE edge.

## Configuration
- `YSYX_22041207_MULDIV_EARLY_OUT_EN` defined:
  - IDLE goes straight to DONE on acceptance when the divisor is zero, on signed overflow, or when either multiply operand is zero.
  - Correct results appear in cycle 1 after acceptance.
- `YSYX_22041207_MULDIV_EARLY_OUT_EN` undefined:
  - These cases run the full N iterations.
  - Results are identical; only the latency differs.

## Test plan
- MUL `src1`=7, `src2`=0xFFFFFFFFFFFFFFFD: `result` 0xFFFFFFFFFFFFFFEB, `out_valid` in cycle 65, `stall` high for 65 cycles.
- MULHU with both operands 0xFFFFFFFFFFFFFFFF: `result` 0xFFFFFFFFFFFFFFFE. MULH on the same operands: `result` 0.
- DIVW `src1`=0x80000000, `src2`=0xFFFFFFFFFFFFFFFF: `result` 0xFFFFFFFF80000000 in cycle 33. REMW on the same operands: `result` 0.
- Divide by zero, `src1`=0x1234:
  - DIVU: `result` 0xFFFFFFFFFFFFFFFF. REMU: `result` 0x1234.
  - Cycle 65 without the macro, cycle 1 with it.
- DIV `src1`=100, `src2`=7:
  - `flush` in cycle 10: no `out_valid`; the next op is accepted on the following edge.
  - `rst_n` low in cycle 20 instead: all outputs return to their reset values immediately.
- REM `src1`=−100, `src2`=7 with `out_ready` held low for 5 cycles after DONE: `result` 0xFFFFFFFFFFFFFFFE (−2) stays stable, `out_valid` stays high, and the next `in_valid` is not accepted until after the handoff.
